// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encodings and hazard helpers for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } hazard_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    // A load into x0 never creates a real dependency, so it must not stall.
    function automatic logic load_use_hazard(
        input logic       memread,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return memread && (rd != REG_X0) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != {CNT_WIDTH{1'b1}})) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - load-use stall, branch flush and data-memory wait sequencing for the 5-stage core
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int CNT_WIDTH   = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                 in_clk,
    input  logic                 in_rst_n,
    input  logic [4:0]           in_ifid_rs1,
    input  logic [4:0]           in_ifid_rs2,
    input  logic                 in_ifid_uses_rs2,
    input  logic                 in_idex_memread,
    input  logic [4:0]           in_idex_rd,
    input  logic                 in_ex_taken,
    input  logic                 in_dmem_req,
    input  logic                 in_dmem_ready,
    input  logic                 in_perf_clear,
    output logic                 out_pc_write,
    output logic                 out_ifid_write,
    output logic                 out_ifid_flush,
    output logic                 out_idex_flush,
    output logic                 out_pipe_hold,
    output logic                 out_memwb_bubble,
    output logic                 out_err,
    output logic [1:0]           out_state,
    output logic [CNT_WIDTH-1:0] out_stall_cnt,
    output logic [CNT_WIDTH-1:0] out_flush_cnt
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    hazard_state_t state_q, state_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          load_use;
    logic          mem_stall;
    logic          stall_inc;
    logic          flush_inc;

    assign load_use  = load_use_hazard(in_idex_memread, in_idex_rd, in_ifid_rs1,
                                       in_ifid_rs2, in_ifid_uses_rs2);
    assign mem_stall = in_dmem_req && !in_dmem_ready;

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_RUN;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
        end
    end

    // tcnt holds the number of MEM_WAIT cycles already spent, including the current one.
    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                    tcnt_d  = TW'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (in_dmem_ready) begin
                    state_d = ST_RUN;
                end else if (tcnt_q == TW'(MEM_TIMEOUT)) begin
                    state_d = ST_ERR;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        out_pc_write     = 1'b1;
        out_ifid_write   = 1'b1;
        out_ifid_flush   = 1'b0;
        out_idex_flush   = 1'b0;
        out_pipe_hold    = 1'b0;
        out_memwb_bubble = 1'b0;
        if ((state_q == ST_RUN && mem_stall) || (state_q == ST_MEM_WAIT && !in_dmem_ready) ||
            state_q == ST_ERR || state_q > ST_ERR) begin
            out_pc_write     = 1'b0;
            out_ifid_write   = 1'b0;
            out_pipe_hold    = 1'b1;
            out_memwb_bubble = 1'b1;
        end else if (in_ex_taken) begin
            out_ifid_flush = 1'b1;
            out_idex_flush = 1'b1;
        end else if (load_use) begin
            out_pc_write   = 1'b0;
            out_ifid_write = 1'b0;
            out_idex_flush = 1'b1;
        end
    end

    assign out_err   = (state_q == ST_ERR);
    assign out_state = state_q;
    assign stall_inc = !out_pc_write && (state_q == ST_RUN || state_q == ST_MEM_WAIT);
    assign flush_inc = out_ifid_flush;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .inc   (stall_inc),
        .clr   (in_perf_clear),
        .q     (out_stall_cnt)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (in_clk),
        .rst_n (in_rst_n),
        .inc   (flush_inc),
        .clr   (in_perf_clear),
        .q     (out_flush_cnt)
    );

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - directed table-driven bench for hazard_controller
module tb_hazard_controller;

    localparam int CW = 8;
    localparam int MT = 4;

    // {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, err, state[1:0]}
    localparam logic [8:0] O_IDLE_R = 9'b1100000_00;
    localparam logic [8:0] O_LU_R   = 9'b0001000_00;
    localparam logic [8:0] O_FL_R   = 9'b1111000_00;
    localparam logic [8:0] O_FRZ_R  = 9'b0000110_00;
    localparam logic [8:0] O_IDLE_W = 9'b1100000_01;
    localparam logic [8:0] O_LU_W   = 9'b0001000_01;
    localparam logic [8:0] O_FL_W   = 9'b1111000_01;
    localparam logic [8:0] O_FRZ_W  = 9'b0000110_01;
    localparam logic [8:0] O_ERR    = 9'b0000111_10;

    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u2;
        logic       mr;
        logic [4:0] rd;
        logic       tk;
        logic       rq;
        logic       rdy;
        logic       clr;
        logic [8:0] outs;
        int         scnt;
        int         fcnt;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic [4:0]    ifid_rs1, ifid_rs2, idex_rd;
    logic          ifid_uses_rs2, idex_memread, ex_taken, dmem_req, dmem_ready, perf_clear;
    logic          pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, err;
    logic [1:0]    state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs [22];
    vec_t v;

    hazard_controller #(.CNT_WIDTH(CW), .MEM_TIMEOUT(MT)) dut (
        .in_clk           (clk),
        .in_rst_n         (rst_n),
        .in_ifid_rs1      (ifid_rs1),
        .in_ifid_rs2      (ifid_rs2),
        .in_ifid_uses_rs2 (ifid_uses_rs2),
        .in_idex_memread  (idex_memread),
        .in_idex_rd       (idex_rd),
        .in_ex_taken      (ex_taken),
        .in_dmem_req      (dmem_req),
        .in_dmem_ready    (dmem_ready),
        .in_perf_clear    (perf_clear),
        .out_pc_write     (pc_write),
        .out_ifid_write   (ifid_write),
        .out_ifid_flush   (ifid_flush),
        .out_idex_flush   (idex_flush),
        .out_pipe_hold    (pipe_hold),
        .out_memwb_bubble (memwb_bubble),
        .out_err          (err),
        .out_state        (state),
        .out_stall_cnt    (stall_cnt),
        .out_flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] dut_outs();
        return {pc_write, ifid_write, ifid_flush, idex_flush, pipe_hold, memwb_bubble, err, state};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                                input logic mr, input logic [4:0] rd, input logic tk,
                                input logic rq, input logic rdy, input logic clr,
                                input logic [8:0] outs, input int scnt, input int fcnt);
        vec_t r;
        r.rs1 = rs1; r.rs2 = rs2; r.u2 = u2; r.mr = mr; r.rd = rd;
        r.tk = tk; r.rq = rq; r.rdy = rdy; r.clr = clr;
        r.outs = outs; r.scnt = scnt; r.fcnt = fcnt;
        return r;
    endfunction

    // Drive one cycle: control outputs are checked before the edge, counters after it.
    task automatic apply(input string name, input vec_t x);
        ifid_rs1 = x.rs1; ifid_rs2 = x.rs2; ifid_uses_rs2 = x.u2;
        idex_memread = x.mr; idex_rd = x.rd; ex_taken = x.tk;
        dmem_req = x.rq; dmem_ready = x.rdy; perf_clear = x.clr;
        #2;
        check({name, " outs"}, int'(dut_outs()), int'(x.outs));
        @(posedge clk);
        #1;
        check({name, " stall_cnt"}, int'(stall_cnt), x.scnt);
        check({name, " flush_cnt"}, int'(flush_cnt), x.fcnt);
    endtask

    initial begin
        rst_n = 1'b0;
        ifid_rs1 = '0; ifid_rs2 = '0; ifid_uses_rs2 = 1'b0; idex_memread = 1'b0;
        idex_rd = '0; ex_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; perf_clear = 1'b0;
        #1;
        check("reset outs", int'(dut_outs()), int'(O_IDLE_R));
        check("reset stall_cnt", int'(stall_cnt), 0);
        check("reset flush_cnt", int'(flush_cnt), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        //             rs1 rs2 u2 mr rd tk rq rdy clr outs     s  f
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE_R, 0, 0);
        vecs[1]  = mk(5, 0, 0, 1, 5, 0, 0, 0, 0, O_LU_R,   1, 0);
        vecs[2]  = mk(5, 0, 0, 0, 5, 0, 0, 0, 0, O_IDLE_R, 1, 0);
        vecs[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 0, O_IDLE_R, 1, 0);
        vecs[4]  = mk(1, 6, 0, 1, 6, 0, 0, 0, 0, O_IDLE_R, 1, 0);
        vecs[5]  = mk(1, 6, 1, 1, 6, 0, 0, 0, 0, O_LU_R,   2, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE_R, 0, 0);
        vecs[7]  = mk(5, 0, 0, 1, 5, 1, 0, 0, 0, O_FL_R,   0, 1);
        vecs[8]  = mk(5, 0, 0, 1, 5, 0, 1, 0, 0, O_FRZ_R,  1, 1);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_W,  2, 1);
        vecs[10] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_W,  3, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_IDLE_W, 3, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE_R, 3, 1);
        vecs[13] = mk(0, 0, 0, 0, 0, 1, 1, 0, 0, O_FRZ_R,  4, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_FRZ_W,  5, 1);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 0, 1, 0, O_FL_W,   5, 2);
        vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_R,  6, 2);
        vecs[17] = mk(5, 0, 0, 1, 5, 0, 0, 1, 0, O_LU_W,   7, 2);
        vecs[18] = mk(5, 0, 0, 1, 5, 0, 0, 0, 1, O_LU_R,   0, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 1, 0, 0, 1, O_FL_R,   0, 0);
        vecs[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, O_IDLE_R, 0, 0);
        vecs[21] = mk(7, 7, 1, 1, 7, 0, 0, 0, 0, O_LU_R,   1, 0);

        for (int i = 0; i < 22; i++) begin
            apply($sformatf("vec%0d", i), vecs[i]);
        end

        // Memory never answers: MT wait cycles, then sticky ERR that ignores ready/taken.
        apply("to_clear", mk(0, 0, 0, 0, 0, 0, 0, 0, 1, O_IDLE_R, 0, 0));
        apply("to_enter", mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_R, 1, 0));
        for (int i = 0; i < MT; i++) begin
            apply($sformatf("to_wait%0d", i), mk(0, 0, 0, 0, 0, 0, 1, 0, 0, O_FRZ_W, 2 + i, 0));
        end
        for (int i = 0; i < 3; i++) begin
            apply($sformatf("err_hold%0d", i), mk(5, 0, 0, 1, 5, 1, 0, 1, 0, O_ERR, MT + 1, 0));
        end

        // Asynchronous reset out of ERR, observed without waiting for a clock edge.
        v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_IDLE_R, 0, 0);
        ifid_rs1 = v.rs1; idex_memread = v.mr; idex_rd = v.rd; ex_taken = v.tk;
        dmem_req = v.rq; dmem_ready = v.rdy;
        rst_n = 1'b0;
        #1;
        check("rst_in_err outs", int'(dut_outs()), int'(O_IDLE_R));
        check("rst_in_err stall_cnt", int'(stall_cnt), 0);
        check("rst_in_err flush_cnt", int'(flush_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply("post_rst", v);

        // Saturation: 8-bit counters must stop at 255.
        for (int i = 0; i < 300; i++) begin
            apply("sat_stall", mk(3, 0, 0, 1, 3, 0, 0, 0, 0, O_LU_R, (i + 1 > 255) ? 255 : i + 1, 0));
        end
        for (int i = 0; i < 300; i++) begin
            apply("sat_flush", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, O_FL_R, 255, (i + 1 > 255) ? 255 : i + 1));
        end
        apply("sat_clear", mk(0, 0, 0, 0, 0, 1, 0, 0, 1, O_FL_R, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
